// File: rtl/pwm_peripheral.sv
// Sixteen-channel PWM generator: prescaled 8-bit period counter, duty shadow
// reloaded at period boundaries, and a registered per-channel output mux.
module pwm_peripheral #(
  parameter int PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] pwm_out,
  output logic        period_start
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] r_pre_cnt;
  logic [7:0]       r_pwm_cnt;
  logic [7:0]       r_duty_sh;
  logic             r_load_pending;

  logic        w_tick;
  logic        w_wrap;
  logic        w_pwm_hi;
  logic [15:0] w_en_out;
  logic [15:0] w_en_pwm;
  logic [15:0] w_chan;

  // The counters hold during the post-reset load cycle so that the first
  // period_start pulse is followed by a full-length period like every other.
  assign w_tick   = !r_load_pending && (r_pre_cnt == PRE_MAX);
  assign w_wrap   = w_tick && (r_pwm_cnt == 8'hFF);
  assign w_pwm_hi = (r_duty_sh == 8'hFF) | (r_pwm_cnt < r_duty_sh);
  assign w_en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign w_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign w_chan   = w_en_out & (~w_en_pwm | {16{w_pwm_hi}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre_cnt      <= '0;
      r_pwm_cnt      <= '0;
      r_duty_sh      <= '0;
      r_load_pending <= 1'b1;
      pwm_out        <= '0;
      period_start   <= 1'b0;
    end else begin
      if (r_load_pending || (r_pre_cnt == PRE_MAX)) begin
        r_pre_cnt <= '0;
      end else begin
        r_pre_cnt <= r_pre_cnt + PRE_W'(1);
      end
      if (w_tick) begin
        r_pwm_cnt <= r_pwm_cnt + 8'd1;
      end
      if (w_wrap || r_load_pending) begin
        r_duty_sh <= pwm_duty_cycle;
      end
      r_load_pending <= 1'b0;
      pwm_out        <= w_chan;
      period_start   <= w_wrap || r_load_pending;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral with PRESCALE=2 (512-cycle period).
module tb_pwm_peripheral;

  localparam int P      = 2;
  localparam int PERIOD = 256 * P;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  eo_lo = 8'h00, eo_hi = 8'h00, ep_lo = 8'h00, ep_hi = 8'h00;
  logic [7:0]  duty = 8'h00;
  logic [15:0] pwm_out;
  logic        period_start;

  int n_checks = 0;
  int n_errors = 0;
  int hi_cnt[16];
  int per_len;

  pwm_peripheral #(.PRESCALE(P)) dut (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (eo_lo),
    .en_reg_out_15_8 (eo_hi),
    .en_reg_pwm_7_0  (ep_lo),
    .en_reg_pwm_15_8 (ep_hi),
    .pwm_duty_cycle  (duty),
    .pwm_out         (pwm_out),
    .period_start    (period_start)
  );

  always #5 clk = ~clk;

  function automatic int exp_hi(logic eo, logic ep, logic [7:0] d);
    if (!eo) return 0;
    if (!ep) return PERIOD;
    if (d == 8'hFF) return PERIOD;
    return int'(d) * P;
  endfunction

  task automatic set_en(logic [15:0] eo, logic [15:0] ep);
    eo_lo = eo[7:0];
    eo_hi = eo[15:8];
    ep_lo = ep[7:0];
    ep_hi = ep[15:8];
  endtask

  // Called on a period_start cycle; counts high cycles per channel up to and
  // including the next period_start cycle. Optionally writes duty mid-period.
  task automatic measure(input int chg_at, input logic [7:0] chg_val);
    per_len = -1;
    for (int i = 0; i < 16; i++) hi_cnt[i] = 0;
    for (int c = 1; c <= 1000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) if (pwm_out[i]) hi_cnt[i]++;
      if (c == chg_at) duty = chg_val;
      if (period_start) begin
        per_len = c;
        break;
      end
    end
    if (per_len < 0) begin
      n_checks++; n_errors++;
      $display("FAIL period_timeout: no period_start within 1000 cycles");
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_en(16'hFFFF, 16'hFFFF);
    duty = 8'hFF;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (pwm_out !== 16'h0000 || period_start !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_hold: pwm_out=%h ps=%b, want 0000/0", pwm_out, period_start);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (period_start !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_first_ps: got %b want 1", period_start);
    end
    n_checks++;
    if (pwm_out !== 16'h0000) begin
      n_errors++;
      $display("FAIL reset_first_out: got %h want 0000", pwm_out);
    end
    measure(-1, 8'h00);
    n_checks++;
    if (per_len !== PERIOD) begin
      n_errors++;
      $display("FAIL reset_period_len: got %0d want %0d", per_len, PERIOD);
    end
    n_checks++;
    if (hi_cnt[0] !== PERIOD || hi_cnt[15] !== PERIOD) begin
      n_errors++;
      $display("FAIL reset_duty_ff: hi0=%0d hi15=%0d want %0d", hi_cnt[0], hi_cnt[15], PERIOD);
    end
  endtask

  task automatic test_enable_latency;
    set_en(16'h0000, 16'h0000);
    @(posedge clk); #1;
    set_en(16'h3C3C, 16'h0000);
    @(posedge clk); #1;
    n_checks++;
    if (pwm_out !== 16'h3C3C) begin
      n_errors++;
      $display("FAIL enable_latency_on: got %h want 3c3c", pwm_out);
    end
    set_en(16'h0000, 16'h0000);
    @(posedge clk); #1;
    n_checks++;
    if (pwm_out !== 16'h0000) begin
      n_errors++;
      $display("FAIL enable_latency_off: got %h want 0000", pwm_out);
    end
    measure(-1, 8'h00);
  endtask

  task automatic test_static;
    set_en(16'h00FF, 16'h0000);
    duty = 8'h80;
    for (int p = 0; p < 2; p++) begin
      measure(-1, 8'h00);
      for (int i = 0; i < 16; i++) begin
        n_checks++;
        if (hi_cnt[i] !== ((i < 8) ? PERIOD : 0)) begin
          n_errors++;
          $display("FAIL static_on bit%0d: hi=%0d want %0d", i, hi_cnt[i], (i < 8) ? PERIOD : 0);
        end
      end
    end
    set_en(16'h0000, 16'hFFFF);
    measure(-1, 8'h00);
    n_checks++;
    if (hi_cnt[0] !== 0 || hi_cnt[9] !== 0 || per_len !== PERIOD) begin
      n_errors++;
      $display("FAIL static_off: hi0=%0d hi9=%0d len=%0d want 0/0/%0d", hi_cnt[0], hi_cnt[9], per_len, PERIOD);
    end
  endtask

  task automatic test_duty_sweep;
    logic [7:0] duties [5];
    int         want   [5];
    duties = '{8'h00, 8'h01, 8'h80, 8'hFE, 8'hFF};
    want   = '{0, 2, 256, 508, 512};
    set_en(16'hFFFF, 16'hFFFF);
    for (int t = 0; t < 5; t++) begin
      duty = duties[t];
      measure(-1, 8'h00);
      measure(-1, 8'h00);
      n_checks++;
      if (per_len !== PERIOD) begin
        n_errors++;
        $display("FAIL sweep_len duty=%h: got %0d want %0d", duties[t], per_len, PERIOD);
      end
      n_checks++;
      if (hi_cnt[0] !== want[t] || hi_cnt[15] !== want[t]) begin
        n_errors++;
        $display("FAIL sweep_hi duty=%h: hi0=%0d hi15=%0d want %0d", duties[t], hi_cnt[0], hi_cnt[15], want[t]);
      end
    end
  endtask

  task automatic test_glitch_free;
    set_en(16'hFFFF, 16'hFFFF);
    duty = 8'h40;
    measure(-1, 8'h00);
    measure(32 * P, 8'hC0);
    n_checks++;
    if (hi_cnt[0] !== 128) begin
      n_errors++;
      $display("FAIL glitch_cur_period: hi=%0d want 128", hi_cnt[0]);
    end
    measure(-1, 8'h00);
    n_checks++;
    if (hi_cnt[0] !== 384) begin
      n_errors++;
      $display("FAIL glitch_next_period: hi=%0d want 384", hi_cnt[0]);
    end
  endtask

  task automatic test_mixed;
    logic [15:0] eo, ep;
    eo = 16'hA5A5;
    ep = 16'h00FF;
    set_en(eo, ep);
    duty = 8'h80;
    measure(-1, 8'h00);
    measure(-1, 8'h00);
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (hi_cnt[i] !== exp_hi(eo[i], ep[i], 8'h80)) begin
        n_errors++;
        $display("FAIL mixed bit%0d: hi=%0d want %0d", i, hi_cnt[i], exp_hi(eo[i], ep[i], 8'h80));
      end
    end
  endtask

  task automatic test_reset_mid;
    set_en(16'hFFFF, 16'hFFFF);
    duty = 8'h80;
    measure(-1, 8'h00);
    repeat (8'h77 * P) @(posedge clk);
    #1;
    n_checks++;
    if (pwm_out !== 16'hFFFF) begin
      n_errors++;
      $display("FAIL mid_pre_reset: got %h want ffff", pwm_out);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (pwm_out !== 16'h0000 || period_start !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_reset_out: pwm_out=%h ps=%b want 0000/0", pwm_out, period_start);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (period_start !== 1'b1 || pwm_out !== 16'h0000) begin
      n_errors++;
      $display("FAIL mid_release: ps=%b pwm_out=%h want 1/0000", period_start, pwm_out);
    end
    measure(-1, 8'h00);
    n_checks++;
    if (per_len !== PERIOD || hi_cnt[3] !== 256) begin
      n_errors++;
      $display("FAIL mid_realign: len=%0d hi=%0d want %0d/256", per_len, hi_cnt[3], PERIOD);
    end
  endtask

  initial begin
    test_reset();
    test_enable_latency();
    test_static();
    test_duty_sweep();
    test_glitch_free();
    test_mixed();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
